// File: rtl/tref_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tref_pkg
// Brief    : Shared constants and helpers for the multi-channel Tref scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package tref_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int PEND_W_DEF = 3;
    localparam int PEND_MAX   = (1 << PEND_W_DEF) - 1;

    // A two-channel build still needs one index bit.
    function automatic int ch_width(input int n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tref_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tref_event_scheduler_if
// Brief    : Valid/ready Tref event channel towards the neuron-update core.
// Revision : 1.0 - initial release
// ============================================================================
interface tref_event_scheduler_if
    import tref_pkg::*;
#(
    parameter int N_CH = 4
) ();

    localparam int CH_W = ch_width(N_CH);

    logic            EVT_VALID;
    logic            EVT_READY;
    logic [CH_W-1:0] EVT_CH;

    modport master (output EVT_VALID, output EVT_CH, input EVT_READY);
    modport slave  (input EVT_VALID, input EVT_CH, output EVT_READY);

endinterface
`default_nettype wire

// File: rtl/tref_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tref_rr_arbiter
// Brief    : Combinational round-robin arbiter searching upward from i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module tref_rr_arbiter
    import tref_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CH_W-1:0] i_ptr,
    output logic [N_CH-1:0] o_grant,
    output logic [CH_W-1:0] o_idx,
    output logic            o_any
);

    logic [CH_W-1:0] w_pos;
    logic            w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_pos   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            w_pos = CH_W'((int'(i_ptr) + k) % N_CH);
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/tref_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tref_event_scheduler
// Brief    : Per-channel period timers with counted requests, arbitrated onto
//            a single valid/ready Tref event stream.
// Revision : 1.0 - initial release
// ============================================================================
module tref_event_scheduler
    import tref_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic [N_CH*CNT_W-1:0] PERIOD,
    input  logic [N_CH-1:0]       TREF_FORCE,
    input  logic                  OVF_CLR,
    output logic [N_CH-1:0]       OVF_FLAG,
    tref_event_scheduler_if.master evt
);

    localparam int              CH_W       = ch_width(N_CH);
    localparam logic [PEND_W-1:0] c_PEND_MAX = '1;

    logic [N_CH-1:0] w_req;
    logic [N_CH-1:0] w_pend_nz;
    logic [N_CH-1:0] w_arb_grant;
    logic [N_CH-1:0] w_grant;
    logic [CH_W-1:0] w_arb_idx;
    logic            w_any;
    logic            w_slot_free;
    logic [CH_W-1:0] r_rr;
    logic [CH_W-1:0] r_evt_ch;
    logic            r_evt_valid;

    assign w_slot_free = !r_evt_valid || evt.EVT_READY;
    assign w_grant     = w_slot_free ? w_arb_grant : '0;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic [CNT_W-1:0]  w_period;
            logic [CNT_W-1:0]  r_cnt;
            logic              w_tick;
            logic              w_sat;
            logic              w_ovf_set;
            logic [PEND_W-1:0] r_pend;
            logic              r_ovf;

            assign w_period  = PERIOD[i*CNT_W +: CNT_W];
            // >= rather than == so a shrunk period wraps immediately.
            assign w_tick    = EN && (w_period != '0) && (r_cnt >= (w_period - CNT_W'(1)));
            assign w_req[i]  = w_tick || TREF_FORCE[i];
            assign w_sat     = (r_pend == c_PEND_MAX);
            assign w_ovf_set = w_req[i] && !w_grant[i] && w_sat;
            assign w_pend_nz[i] = (r_pend != '0);
            assign OVF_FLAG[i]  = r_ovf;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_cnt <= '0;
                end else if (w_period == '0) begin
                    r_cnt <= '0;
                end else if (EN) begin
                    r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_pend <= '0;
                    r_ovf  <= 1'b0;
                end else begin
                    if (w_req[i] && !w_grant[i] && !w_sat) begin
                        r_pend <= r_pend + PEND_W'(1);
                    end else if (!w_req[i] && w_grant[i]) begin
                        r_pend <= r_pend - PEND_W'(1);
                    end
                    r_ovf <= w_ovf_set || (r_ovf && !OVF_CLR);
                end
            end
        end
    endgenerate

    tref_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .i_req   (w_pend_nz),
        .i_ptr   (r_rr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_rr        <= '0;
        end else if (w_slot_free) begin
            r_evt_valid <= w_any;
            if (w_any) begin
                r_evt_ch <= w_arb_idx;
                r_rr     <= (w_arb_idx == CH_W'(N_CH - 1)) ? '0 : w_arb_idx + CH_W'(1);
            end
        end
    end

    assign evt.EVT_VALID = r_evt_valid;
    assign evt.EVT_CH    = r_evt_ch;

endmodule
`default_nettype wire
